// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, reset/bubble
// defaults and the sequential PC increment.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INCR          = 32'd4;

    // Sequential successor of a PC; wraps modulo 2^32.
    function automatic logic [31:0] incr_pc(input logic [31:0] pc);
        return pc + PC_INCR;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_next_pc_select.sv
// Next-PC mux for the fetch unit: reset, then branch, then jump, then sequential
// advance; otherwise the PC holds.
module instruction_fetch_unit_next_pc_select
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        reset_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        advance_i,
    input  logic [31:0] pc_q_i,
    output logic        redirect_o,
    output logic [31:0] pc_seq_o,
    output logic [31:0] pc_d_o
);

    always_comb begin
        redirect_o = branch_taken_i | jump_i;
        pc_seq_o   = incr_pc(pc_q_i);
        // NOTE: pc_d_o takes a default before the priority chain so every path
        // assigns it and no latch is inferred.
        pc_d_o     = pc_q_i;
        if (reset_i) begin
            pc_d_o = RESET_PC;
        end else if (branch_taken_i) begin
            pc_d_o = branch_target_i;
        end else if (jump_i) begin
            pc_d_o = jump_target_i;
        end else if (advance_i) begin
            pc_d_o = pc_seq_o;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a valid-strobe memory handshake
// and feeds {instruction, PC+4} to the IF/ID register, honouring stall and redirect.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    input  logic        JUMP,
    input  logic [31:0] JUMP_TARGET,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_VALID,
    input  logic [31:0] IMEM_RDATA,
    output logic [31:0] Instruction_Out,
    output logic [31:0] PCPlus4_Out,
    output logic        FETCH_VALID,
    output logic        FLUSH_OUT
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  pc_seq;
    logic [31:0]  hold_q;
    logic [31:0]  pc4_q;
    logic         fetch_valid_q;
    logic         redirect;
    logic         advance;
    logic         resp_in_flight;
    logic         outstanding_d;

    assign advance   = (state_q == S_HOLD) && !STALL;
    assign IMEM_REQ  = !RESET && ((state_q == S_REQ) || advance);
    assign IMEM_ADDR = (state_q == S_HOLD) ? pc_seq : pc_q;

    // A response is still owed after this edge if one was pending and did not
    // arrive now, or if a new request goes out this cycle.
    assign resp_in_flight = ((state_q == S_WAIT) || (state_q == S_DRAIN)) && !IMEM_VALID;
    assign outstanding_d  = IMEM_REQ || resp_in_flight;

    assign FLUSH_OUT       = redirect && !RESET;
    assign FETCH_VALID     = fetch_valid_q;
    assign Instruction_Out = fetch_valid_q ? hold_q : NOP_WORD;
    assign PCPlus4_Out     = pc4_q;

    instruction_fetch_unit_next_pc_select #(
        .RESET_PC (RESET_PC)
    ) u_next_pc (
        .reset_i         (RESET),
        .branch_taken_i  (BRANCH_TAKEN),
        .branch_target_i (BRANCH_TARGET),
        .jump_i          (JUMP),
        .jump_target_i   (JUMP_TARGET),
        .advance_i       (advance),
        .pc_q_i          (pc_q),
        .redirect_o      (redirect),
        .pc_seq_o        (pc_seq),
        .pc_d_o          (pc_d)
    );

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK) begin
        pc_q <= pc_d;
        if (RESET || redirect) begin
            fetch_valid_q <= 1'b0;
            hold_q        <= NOP_WORD;
            if (RESET) begin
                pc4_q <= incr_pc(RESET_PC);
            end
            // A late response to an abandoned request must be swallowed first.
            if (outstanding_d) begin
                state_q <= S_DRAIN;
            end else begin
                state_q <= S_REQ;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (IMEM_VALID) begin
                        hold_q        <= IMEM_RDATA;
                        pc4_q         <= pc_seq;
                        fetch_valid_q <= 1'b1;
                        state_q       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!STALL) begin
                        fetch_valid_q <= 1'b0;
                        state_q       <= S_WAIT;
                    end
                end
                S_DRAIN: begin
                    if (IMEM_VALID) begin
                        state_q <= S_REQ;
                    end
                end
                default: begin
                    state_q <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios, then random
// stall/redirect/reset traffic against a transaction-level reference model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        CLOCK = 1'b0;
    logic        RESET, STALL, BRANCH_TAKEN, JUMP, IMEM_VALID;
    logic [31:0] BRANCH_TARGET, JUMP_TARGET, IMEM_RDATA;
    logic        IMEM_REQ, FETCH_VALID, FLUSH_OUT;
    logic [31:0] IMEM_ADDR, Instruction_Out, PCPlus4_Out;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Values sampled mid-cycle from the DUT.
    logic        s_req, s_flush, s_fv;
    logic [31:0] s_addr, s_instr, s_pc4;

    // Reference model: facts about the fetch stream rather than FSM states.
    logic        m_valid = 1'b0;   // a fetched word is being presented
    logic        m_out   = 1'b0;   // a memory response is still owed
    logic        m_stale = 1'b0;   // that owed response belongs to an abandoned fetch
    logic [31:0] m_pc    = RST_PC; // address of the presented / next fetch
    logic [31:0] m_word  = '0;
    logic [31:0] m_pc4   = '0;

    // Memory responder.
    logic        mem_pending = 1'b0;
    int          mem_count   = 0;
    int          mem_lat     = 1;
    logic [31:0] req_log[$];
    int          req_cyc[$];

    always #5 CLOCK = ~CLOCK;

    instruction_fetch_unit #(
        .RESET_PC (RST_PC),
        .NOP_WORD (NOP)
    ) dut (
        .CLOCK           (CLOCK),
        .RESET           (RESET),
        .STALL           (STALL),
        .BRANCH_TAKEN    (BRANCH_TAKEN),
        .BRANCH_TARGET   (BRANCH_TARGET),
        .JUMP            (JUMP),
        .JUMP_TARGET     (JUMP_TARGET),
        .IMEM_REQ        (IMEM_REQ),
        .IMEM_ADDR       (IMEM_ADDR),
        .IMEM_VALID      (IMEM_VALID),
        .IMEM_RDATA      (IMEM_RDATA),
        .Instruction_Out (Instruction_Out),
        .PCPlus4_Out     (PCPlus4_Out),
        .FETCH_VALID     (FETCH_VALID),
        .FLUSH_OUT       (FLUSH_OUT)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom();
        if ($urandom_range(0, 3) == 0) begin
            t = 32'hFFFF_FFF8 + 32'($urandom_range(0, 1) * 4);
        end else begin
            t[1:0] = 2'b00;
        end
        return t;
    endfunction

    // One clock: drive memory response, sample and check mid-cycle, advance model.
    task automatic step(input bit chk);
        logic        exp_req, exp_flush, out_after;
        logic [31:0] exp_addr;
        if (mem_pending && mem_count == 0) begin
            IMEM_VALID = 1'b1;
            IMEM_RDATA = $urandom();
        end else begin
            IMEM_VALID = 1'b0;
            IMEM_RDATA = 32'hDEAD_BEEF;
        end
        #3;
        s_req   = IMEM_REQ;
        s_addr  = IMEM_ADDR;
        s_flush = FLUSH_OUT;
        s_fv    = FETCH_VALID;
        s_instr = Instruction_Out;
        s_pc4   = PCPlus4_Out;

        exp_req   = !RESET && ((!m_out && !m_valid) || (m_valid && !STALL));
        exp_addr  = m_valid ? m_pc + 32'd4 : m_pc;
        exp_flush = !RESET && (BRANCH_TAKEN || JUMP);
        if (chk) begin
            check("imem_req", 32'(s_req), 32'(exp_req));
            if (exp_req) check("imem_addr", s_addr, exp_addr);
            check("flush_out", 32'(s_flush), 32'(exp_flush));
            check("fetch_valid", 32'(s_fv), 32'(m_valid));
            check("instruction_out", s_instr, m_valid ? m_word : NOP);
            if (m_valid) check("pcplus4_out", s_pc4, m_pc4);
        end

        @(posedge CLOCK);
        out_after = (m_out && !IMEM_VALID) || exp_req;
        if (RESET) begin
            m_pc    = RST_PC;
            m_valid = 1'b0;
            m_out   = out_after;
            m_stale = out_after;
        end else if (BRANCH_TAKEN || JUMP) begin
            m_pc    = BRANCH_TAKEN ? BRANCH_TARGET : JUMP_TARGET;
            m_valid = 1'b0;
            m_out   = out_after;
            m_stale = out_after;
        end else begin
            if (m_out && IMEM_VALID) begin
                if (!m_stale) begin
                    m_valid = 1'b1;
                    m_word  = IMEM_RDATA;
                    m_pc4   = m_pc + 32'd4;
                end
                m_out = 1'b0;
            end
            if (exp_req) begin
                if (m_valid) begin
                    m_pc    = m_pc + 32'd4;
                    m_valid = 1'b0;
                end
                m_out   = 1'b1;
                m_stale = 1'b0;
            end
        end

        if (IMEM_VALID) mem_pending = 1'b0;
        else if (mem_pending && mem_count > 0) mem_count--;
        if (s_req) begin
            mem_pending = 1'b1;
            mem_count   = mem_lat - 1;
            req_log.push_back(s_addr);
            req_cyc.push_back(cyc);
        end
        cyc++;
        #1;
    endtask

    initial begin
        RESET = 1'b1; STALL = 1'b0; BRANCH_TAKEN = 1'b0; JUMP = 1'b0;
        BRANCH_TARGET = '0; JUMP_TARGET = '0; IMEM_VALID = 1'b0; IMEM_RDATA = '0;

        // Reset state.
        step(0);
        step(1);
        check("rst_req", 32'(s_req), 32'd0);
        check("rst_fetch_valid", 32'(s_fv), 32'd0);
        check("rst_instr", s_instr, NOP);
        check("rst_flush", 32'(s_flush), 32'd0);
        RESET = 1'b0;
        req_log.delete();
        req_cyc.delete();

        // Free run, single-cycle memory.
        repeat (6) step(1);
        check("run_req_count", 32'(req_log.size()), 32'd3);
        for (int i = 0; i < req_log.size() && i < 3; i++) check("run_addr_seq", req_log[i], 32'(i * 4));
        for (int i = 1; i < req_cyc.size() && i < 3; i++) check("run_req_spacing", 32'(req_cyc[i] - req_cyc[i-1]), 32'd2);

        // Stall in S_HOLD holding the word from PC=8.
        STALL = 1'b1;
        repeat (3) begin
            step(1);
            check("stall_req", 32'(s_req), 32'd0);
            check("stall_pc4", s_pc4, 32'hC);
            check("stall_fetch_valid", 32'(s_fv), 32'd1);
        end
        STALL = 1'b0;
        step(1);
        check("unstall_req", 32'(s_req), 32'd1);
        check("unstall_addr", s_addr, 32'hC);
        step(1);
        mem_lat = 3;
        step(1);
        check("seq_pc4_10", s_pc4, 32'h10);
        check("seq_addr_10", s_addr, 32'h10);

        // Branch while waiting; response lands two cycles later and is dropped.
        BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h40;
        step(1);
        BRANCH_TAKEN = 1'b0;
        check("br_flush", 32'(s_flush), 32'd1);
        step(1);
        check("br_flush_once", 32'(s_flush), 32'd0);
        check("br_drain_fv", 32'(s_fv), 32'd0);
        step(1);
        check("br_drain_req", 32'(s_req), 32'd0);
        check("br_late_fv", 32'(s_fv), 32'd0);
        mem_lat = 1;
        step(1);
        check("br_req", 32'(s_req), 32'd1);
        check("br_addr", s_addr, 32'h40);
        step(1);
        check("br_wait_fv", 32'(s_fv), 32'd0);

        // Branch and jump together under stall: branch target wins.
        STALL = 1'b1; BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h80;
        JUMP = 1'b1; JUMP_TARGET = 32'h100;
        step(1);
        check("bj_fetch_valid", 32'(s_fv), 32'd1);
        check("bj_pc4", s_pc4, 32'h44);
        check("bj_flush", 32'(s_flush), 32'd1);
        check("bj_req", 32'(s_req), 32'd0);
        STALL = 1'b0; BRANCH_TAKEN = 1'b0; JUMP = 1'b0;
        step(1);
        check("bj_addr", s_addr, 32'h80);
        step(1);

        // Jump to the top of the address space from S_HOLD with a request going out.
        JUMP = 1'b1; JUMP_TARGET = 32'hFFFF_FFFC;
        step(1);
        JUMP = 1'b0;
        check("j_pc4", s_pc4, 32'h84);
        check("j_flush", 32'(s_flush), 32'd1);
        check("j_req_hold", 32'(s_req), 32'd1);
        step(1);
        check("j_drain_req", 32'(s_req), 32'd0);
        step(1);
        check("wrap_fetch_addr", s_addr, 32'hFFFF_FFFC);
        step(1);
        mem_lat = 2;
        step(1);
        check("wrap_pc4", s_pc4, 32'h0);
        check("wrap_next_addr", s_addr, 32'h0);

        // Reset while waiting; the response arrives the cycle after.
        RESET = 1'b1;
        step(1);
        RESET = 1'b0;
        step(1);
        check("rst_late_req", 32'(s_req), 32'd0);
        check("rst_late_fv", 32'(s_fv), 32'd0);
        check("rst_late_instr", s_instr, NOP);
        mem_lat = 1;
        step(1);
        check("rst_first_req", 32'(s_req), 32'd1);
        check("rst_first_addr", s_addr, RST_PC);
        step(1);
        check("rst_wait_instr", s_instr, NOP);
        step(1);
        check("rst_new_fv", 32'(s_fv), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            STALL         = ($urandom_range(0, 9) < 3);
            BRANCH_TAKEN  = ($urandom_range(0, 15) == 0);
            JUMP          = ($urandom_range(0, 15) == 0);
            BRANCH_TARGET = rand_target();
            JUMP_TARGET   = rand_target();
            RESET         = ($urandom_range(0, 63) == 0);
            mem_lat       = $urandom_range(1, 4);
            step(1);
        end
        RESET = 1'b0; STALL = 1'b0; BRANCH_TAKEN = 1'b0; JUMP = 1'b0;
        repeat (10) step(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
